// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the SRAM burst client: the burst FSM state type,
// SRAM word geometry and the controller's core_mem wr encoding.
// -----------------------------------------------------------------------------
package sram_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    // The controller uses wr=1 for a read and wr=0 for a write.
    localparam logic MEM_WR_READ  = 1'b1;
    localparam logic MEM_WR_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        DRAIN,
        DONE
    } state_t;

    // Word address of beat 'offset' in a burst; wraps at the top of the
    // 20-bit address space.
    function automatic logic [SRAM_ADDR_W-1:0] word_addr(
        input logic [SRAM_ADDR_W-1:0] base,
        input logic [SRAM_ADDR_W-1:0] offset
    );
        return base + offset;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO used as the stream buffer of the burst client.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear            synchronous flush (drops all contents)
//   push, din        write side
//   pop, dout        read side; dout is the current head
//   full, empty      status flags
//   count            occupancy in words (0..DEPTH)
// Push and pop in the same cycle are both honoured even when full or empty,
// leaving occupancy unchanged.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        empty   = (count_q == '0);
        count   = count_q;
        // When empty the incoming word is forwarded so a same-cycle
        // push/pop passes straight through.
        dout    = empty ? din : mem[rd_ptr];
        do_push = push & (~full | pop);
        do_pop  = pop & (~empty | push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/sram_burst_client.sv
// -----------------------------------------------------------------------------
// sram_burst_client
// Core-side initiator for the SRAM controller's core_mem handshake. Moves a
// burst of i_len 16-bit words between a valid/ready stream and consecutive
// SRAM word addresses, in either direction, buffered through sync_fifo.
// Ports:
//   i_clk, i_rst              clock, asynchronous active-low reset
//   i_start, i_dir            burst start pulse; 1 = SRAM->stream, 0 = stream->SRAM
//   i_base_addr, i_len        first word address, number of words
//   o_busy, o_done, o_error   burst in progress, end pulse, sticky timeout flag
//   o_mem_*/i_mem_*           controller handshake (request/wr/addr/w_value,
//                             r_value/wait)
//   o_rd_data/o_rd_valid/i_rd_ready   read stream (FIFO head)
//   i_wr_data/i_wr_valid/o_wr_ready   write stream
// -----------------------------------------------------------------------------
module sram_burst_client
    import sram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 32,
    parameter int LEN_W      = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_dir,
    input  logic [SRAM_ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]       i_len,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic                   o_mem_request,
    output logic                   o_mem_wr,
    output logic [SRAM_ADDR_W-1:0] o_mem_addr,
    output logic [SRAM_DATA_W-1:0] o_mem_w_value,
    input  logic [SRAM_DATA_W-1:0] i_mem_r_value,
    input  logic                   i_mem_wait,
    output logic [SRAM_DATA_W-1:0] o_rd_data,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    input  logic [SRAM_DATA_W-1:0] i_wr_data,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    state_t                 state;
    logic                   dir;          // latched i_dir: 1 = read burst
    logic [SRAM_ADDR_W-1:0] base;
    logic [LEN_W-1:0]       len;
    logic [LEN_W-1:0]       idx;          // SRAM transactions completed
    logic [LEN_W-1:0]       idx_next;
    logic [LEN_W-1:0]       accepted;     // write-stream beats taken
    logic [TIMER_W-1:0]     timer;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_clear;
    logic [SRAM_DATA_W-1:0] fifo_din;
    logic [SRAM_DATA_W-1:0] fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

    logic                   mem_done;     // controller finished the transaction
    logic                   phase_timeout;
    logic                   can_issue;
    logic                   wr_ready;

    sync_fifo #(
        .WIDTH (SRAM_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst),
        .clear (fifo_clear),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        idx_next      = idx + 1'b1;
        mem_done      = (state == WAIT_LO) && !i_mem_wait;
        phase_timeout = (((state == WAIT_HI) && !i_mem_wait) ||
                         ((state == WAIT_LO) &&  i_mem_wait)) &&
                        (timer == TIMER_LAST);
        // Read bursts need room for the returning word; write bursts need a
        // word to send.
        can_issue     = dir ? (fifo_count != CNT_W'(FIFO_DEPTH))
                            : (fifo_count != '0);
        // DONE is excluded so nothing lands in the FIFO after a timeout flush.
        wr_ready      = o_busy && !dir && (state != DONE) && !fifo_full &&
                        (accepted < len);
        o_wr_ready    = wr_ready;
        o_rd_valid    = o_busy && dir && !fifo_empty;
        o_rd_data     = o_rd_valid ? fifo_dout : '0;
        fifo_clear    = phase_timeout;
        if (dir) begin
            fifo_push = mem_done;
            fifo_din  = i_mem_r_value;
            fifo_pop  = o_rd_valid && i_rd_ready;
        end else begin
            fifo_push = i_wr_valid && wr_ready;
            fifo_din  = i_wr_data;
            fifo_pop  = mem_done;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state         <= IDLE;
            dir           <= 1'b0;
            base          <= '0;
            len           <= '0;
            idx           <= '0;
            accepted      <= '0;
            timer         <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_mem_request <= 1'b0;
            o_mem_wr      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_w_value <= '0;
        end else begin
            o_mem_request <= 1'b0;
            o_done        <= 1'b0;

            if (fifo_push && !dir) begin
                accepted <= accepted + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        base     <= i_base_addr;
                        len      <= i_len;
                        dir      <= i_dir;
                        idx      <= '0;
                        accepted <= '0;
                        o_error  <= 1'b0;
                        o_busy   <= 1'b1;
                        if (i_len == '0) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end

                // Holds until the FIFO allows the next beat, then fires one
                // request; it is visible during the first WAIT_HI cycle.
                ISSUE: begin
                    if (can_issue) begin
                        o_mem_request <= 1'b1;
                        o_mem_wr      <= dir ? MEM_WR_READ : MEM_WR_WRITE;
                        o_mem_addr    <= word_addr(base, SRAM_ADDR_W'(idx));
                        if (!dir) begin
                            o_mem_w_value <= fifo_dout;
                        end
                        timer <= '0;
                        state <= WAIT_HI;
                    end
                end

                WAIT_HI: begin
                    if (i_mem_wait) begin
                        timer <= '0;
                        state <= WAIT_LO;
                    end else if (phase_timeout) begin
                        o_error <= 1'b1;
                        o_done  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WAIT_LO: begin
                    if (!i_mem_wait) begin
                        idx <= idx_next;
                        if (idx_next == len) begin
                            if (dir) begin
                                state <= DRAIN;
                            end else begin
                                o_done <= 1'b1;
                                state  <= DONE;
                            end
                        end else begin
                            state <= ISSUE;
                        end
                    end else if (phase_timeout) begin
                        o_error <= 1'b1;
                        o_done  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DRAIN: begin
                    if (fifo_empty) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_client.sv
module tb_sram_burst_client;

    localparam int TO    = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_dir = 1'b0;
    logic [19:0] i_base_addr = '0;
    logic [9:0]  i_len = '0;
    logic        o_busy, o_done, o_error, o_mem_request, o_mem_wr;
    logic [19:0] o_mem_addr;
    logic [15:0] o_mem_w_value;
    logic [15:0] i_mem_r_value = '0;
    logic        i_mem_wait = 1'b0;
    logic [15:0] o_rd_data;
    logic        o_rd_valid;
    logic        i_rd_ready = 1'b0;
    logic [15:0] i_wr_data = '0;
    logic        i_wr_valid = 1'b0;
    logic        o_wr_ready;

    sram_burst_client #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TO),
        .LEN_W      (10)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_dir         (i_dir),
        .i_base_addr   (i_base_addr),
        .i_len         (i_len),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_mem_request (o_mem_request),
        .o_mem_wr      (o_mem_wr),
        .o_mem_addr    (o_mem_addr),
        .o_mem_w_value (o_mem_w_value),
        .i_mem_r_value (i_mem_r_value),
        .i_mem_wait    (i_mem_wait),
        .o_rd_data     (o_rd_data),
        .o_rd_valid    (o_rd_valid),
        .i_rd_ready    (i_rd_ready),
        .i_wr_data     (i_wr_data),
        .i_wr_valid    (i_wr_valid),
        .o_wr_ready    (o_wr_ready)
    );

    int checks = 0;
    int errors = 0;

    // controller model / stream agents state
    int          hold = 4;
    int          dead_after = 1000;
    int          hold_cnt = 0;
    int          cyc = 0;
    int          viol = 0;
    int          req_n = 0;
    int          rd_n = 0;
    int          done_n = 0;
    int          done_cyc = 0;
    logic [19:0] req_addr  [64];
    logic        req_wr    [64];
    logic [15:0] req_wdata [64];
    int          req_cyc   [64];
    logic [15:0] rd_log    [64];
    logic [15:0] wr_src    [16];
    int          wr_len_q = 0;
    int          wr_pos = 0;
    logic        rd_ready_en = 1'b1;

    // All agents act on the falling edge; the DUT samples on the rising one.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!i_rst) begin
            i_mem_wait = 1'b0;
            hold_cnt   = 0;
        end else begin
            if (o_mem_request) begin
                if (i_mem_wait) viol = viol + 1;
                if (req_n < 64) begin
                    req_addr[req_n]  = o_mem_addr;
                    req_wr[req_n]    = o_mem_wr;
                    req_wdata[req_n] = o_mem_w_value;
                    req_cyc[req_n]   = cyc;
                end
                if (req_n < dead_after) begin
                    i_mem_wait    = 1'b1;
                    hold_cnt      = hold;
                    i_mem_r_value = o_mem_addr[15:0];
                end
                req_n = req_n + 1;
            end else if (i_mem_wait) begin
                if (hold_cnt > 1) hold_cnt = hold_cnt - 1;
                else i_mem_wait = 1'b0;
            end
        end
        if (o_done) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
        if (o_rd_valid && rd_ready_en) begin
            if (rd_n < 64) rd_log[rd_n] = o_rd_data;
            rd_n = rd_n + 1;
        end
        i_rd_ready = rd_ready_en;
        if (wr_pos < wr_len_q) begin
            i_wr_valid = 1'b1;
            i_wr_data  = wr_src[wr_pos];
            if (o_wr_ready) wr_pos = wr_pos + 1;
        end else begin
            i_wr_valid = 1'b0;
            i_wr_data  = '0;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: actual 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs;
        req_n  = 0;
        rd_n   = 0;
        done_n = 0;
    endtask

    task automatic start_burst(input logic dir, input logic [19:0] base, input logic [9:0] len);
        i_start     = 1'b1;
        i_dir       = dir;
        i_base_addr = base;
        i_len       = len;
        tick;
        i_start     = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 1;
        while (done_n == 0 && cycles < 2000) begin
            tick;
            cycles = cycles + 1;
        end
        chk("done_seen", 32'(done_n), 32'd1);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_flags"},
            32'({o_busy, o_done, o_error, o_mem_request, o_mem_wr, o_rd_valid, o_wr_ready}), 32'd0);
        chk({name, "_addr"}, 32'(o_mem_addr), 32'd0);
        chk({name, "_data"}, {o_mem_w_value, o_rd_data}, 32'd0);
    endtask

    typedef struct {
        logic        dir;
        logic [19:0] base;
        logic [9:0]  len;
        int          hold;
        logic [15:0] wd0;
        logic [15:0] wstep;
        logic [19:0] exp_last_addr;
        logic [15:0] exp_last_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vec_t        v;
        int          cycles;
        logic [19:0] ea;
        logic [15:0] ed;

        vecs[0] = '{1'b1, 20'h00100, 10'd4, 8, 16'h0000, 16'h0000, 20'h00103, 16'h0103};
        vecs[1] = '{1'b0, 20'hFFFFE, 10'd3, 2, 16'hAAAA, 16'h1111, 20'h00000, 16'hCCCC};
        vecs[2] = '{1'b1, 20'hFFFFE, 10'd3, 1, 16'h0000, 16'h0000, 20'h00000, 16'h0000};
        vecs[3] = '{1'b0, 20'h00010, 10'd5, 3, 16'h1000, 16'h0101, 20'h00014, 16'h1404};
        vecs[4] = '{1'b1, 20'h12345, 10'd1, 3, 16'h0000, 16'h0000, 20'h12345, 16'h2345};

        // reset state
        i_rst = 1'b0;
        repeat (3) tick;
        chk_zero("reset");
        i_rst = 1'b1;
        tick;

        // table-driven bursts
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            hold = v.hold;
            rd_ready_en = 1'b1;
            wr_pos = 0;
            if (!v.dir) begin
                for (int k = 0; k <= int'(v.len); k++)
                    wr_src[k] = 16'(v.wd0 + 16'(k) * v.wstep);
                wr_len_q = int'(v.len) + 1;   // one surplus beat
            end else begin
                wr_len_q = 0;
            end
            clear_logs;
            start_burst(v.dir, v.base, v.len);
            wait_done(cycles);
            chk("vec_req_count", 32'(req_n), 32'(v.len));
            chk("vec_error", 32'(o_error), 32'd0);
            for (int k = 0; k < int'(v.len); k++) begin
                ea = v.base + 20'(k);
                chk("vec_addr", 32'(req_addr[k]), 32'(ea));
                chk("vec_wr", 32'(req_wr[k]), 32'(v.dir));
                if (v.dir) begin
                    chk("vec_rdata", 32'(rd_log[k]), 32'(ea[15:0]));
                end else begin
                    ed = 16'(v.wd0 + 16'(k) * v.wstep);
                    chk("vec_wdata", 32'(req_wdata[k]), 32'(ed));
                end
            end
            chk("vec_last_addr", 32'(req_addr[v.len - 1]), 32'(v.exp_last_addr));
            if (v.dir) begin
                chk("vec_last_rdata", 32'(rd_log[v.len - 1]), 32'(v.exp_last_data));
                chk("vec_rd_beats", 32'(rd_n), 32'(v.len));
            end else begin
                chk("vec_last_wdata", 32'(req_wdata[v.len - 1]), 32'(v.exp_last_data));
                chk("vec_wr_beats", 32'(wr_pos), 32'(v.len));
            end
            tick;
            chk("vec_busy_after", 32'(o_busy), 32'd0);
            chk("vec_done_pulses", 32'(done_n), 32'd1);
            wr_len_q = 0;
        end

        // read backpressure, plus a start pulse while busy
        hold = 2;
        rd_ready_en = 1'b0;
        clear_logs;
        start_burst(1'b1, 20'h00200, 10'd8);
        repeat (10) tick;
        start_burst(1'b0, 20'h55555, 10'd1);
        repeat (40) tick;
        chk("bp_stalled_reqs", 32'(req_n), 32'd4);
        chk("bp_no_reads", 32'(rd_n), 32'd0);
        chk("bp_busy", 32'(o_busy), 32'd1);
        rd_ready_en = 1'b1;
        wait_done(cycles);
        chk("bp_total_reqs", 32'(req_n), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("bp_addr", 32'(req_addr[k]), 32'h200 + 32'(k));
            chk("bp_rdata", 32'(rd_log[k]), 32'h0200 + 32'(k));
        end
        chk("bp_error", 32'(o_error), 32'd0);
        tick;

        // timeout on the second request
        hold = 2;
        dead_after = 1;
        rd_ready_en = 1'b0;
        clear_logs;
        start_burst(1'b1, 20'h00300, 10'd4);
        wait_done(cycles);
        chk("to_reqs", 32'(req_n), 32'd2);
        chk("to_latency", 32'(done_cyc - req_cyc[1]), 32'(TO));
        chk("to_error", 32'(o_error), 32'd1);
        chk("to_fifo_flushed", 32'(o_rd_valid), 32'd0);
        tick;
        chk("to_error_sticky", 32'(o_error), 32'd1);
        chk("to_busy_after", 32'(o_busy), 32'd0);
        chk("to_done_pulses", 32'(done_n), 32'd1);
        dead_after = 1000;
        rd_ready_en = 1'b1;

        // zero-length burst; also clears the sticky error
        clear_logs;
        start_burst(1'b1, 20'h00000, 10'd0);
        chk("len0_done_next", 32'(o_done), 32'd1);
        chk("len0_error_cleared", 32'(o_error), 32'd0);
        wait_done(cycles);
        chk("len0_latency", 32'(cycles), 32'd1);
        tick;
        chk("len0_done_single", 32'(o_done), 32'd0);
        chk("len0_no_request", 32'(req_n), 32'd0);

        // reset in WAIT_LO, after an ignored start while busy
        hold = 8;
        clear_logs;
        start_burst(1'b1, 20'h00400, 10'd4);
        for (int t = 0; t < 20 && req_n == 0; t++) tick;
        chk("rst_first_req", 32'(req_n), 32'd1);
        tick;
        start_burst(1'b0, 20'h55555, 10'd1);
        i_rst = 1'b0;
        #1;
        chk_zero("rst_async");
        tick;
        chk_zero("rst_hold");
        chk("rst_req_count", 32'(req_n), 32'd1);
        chk("rst_req_addr", 32'(req_addr[0]), 32'h00400);
        i_rst = 1'b1;
        tick;
        clear_logs;
        start_burst(1'b1, 20'h00400, 10'd2);
        wait_done(cycles);
        chk("post_rst_reqs", 32'(req_n), 32'd2);
        chk("post_rst_addr1", 32'(req_addr[1]), 32'h00401);
        chk("post_rst_rdata0", 32'(rd_log[0]), 32'h0400);
        chk("post_rst_rdata1", 32'(rd_log[1]), 32'h0401);
        chk("post_rst_error", 32'(o_error), 32'd0);
        tick;

        chk("no_request_while_wait", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_burst_client.md
Name: sram_burst_client

Overview:
- Core-side initiator for the SRAM controller's core_mem handshake (request / wr / addr / w_value in; r_value / wait out).
- Moves a burst of LEN 16-bit words between a valid/ready stream and consecutive SRAM addresses, in either direction.
- Buffers through a small FIFO so the stream side never sees SRAM latency directly.
- Sits between the recognition/feature logic and the SRAM controller.

Parameters:
- FIFO_DEPTH, 4, stream buffer depth in words (power of two, >=2).
- TIMEOUT, 32, max cycles allowed in either wait phase before abort.
- LEN_W, 10, width of burst length.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle burst start; ignored while o_busy
- i_dir  in  1  1 = SRAM->stream (read), 0 = stream->SRAM (write)
- i_base_addr  in  20  first SRAM word address
- i_len  in  LEN_W  number of words
- o_busy  out  1  burst in progress
- o_done  out  1  one-cycle pulse at burst end
- o_error  out  1  sticky timeout flag; cleared by next accepted i_start
- o_mem_request  out  1  one-cycle request to the controller
- o_mem_wr  out  1  controller encoding: 1 = read, 0 = write
- o_mem_addr  out  20  transaction address
- o_mem_w_value  out  16  write data
- i_mem_r_value  in  16  read data from the controller
- i_mem_wait  in  1  controller busy
- o_rd_data  out  16  read stream data (FIFO head)
- o_rd_valid  out  1  read stream valid
- i_rd_ready  in  1  read stream ready
- i_wr_data  in  16  write stream data
- i_wr_valid  in  1  write stream valid
- o_wr_ready  out  1  write stream ready

Behaviour:
- Reset: state IDLE, FIFO empty, counters 0; all outputs 0, o_mem_addr/o_mem_w_value 0.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, DRAIN, DONE.
- IDLE:
  - i_start accepted: latch base, len, dir; clear o_error; idx=0; o_busy=1.
  - len==0 goes to DONE directly.
  - Otherwise go to ISSUE.
- ISSUE:
  - Read: enter only when FIFO has a free slot.
  - Write: enter only when FIFO is non-empty.
  - o_mem_request=1 for exactly one cycle with o_mem_addr = base+idx (20-bit wrap, 0xFFFFF+1 -> 0x00000).
  - Write: o_mem_w_value = FIFO head.
  - Next state: WAIT_HI.
- WAIT_HI: wait for i_mem_wait=1, then go to WAIT_LO.
- WAIT_LO:
  - On the first cycle i_mem_wait=0: read pushes i_mem_r_value into the FIFO; write pops the FIFO head.
  - Then idx++. If idx==len, go to DRAIN (read) or DONE (write); otherwise go to ISSUE.
- Timeout: a per-phase cycle counter reaching TIMEOUT in WAIT_HI or WAIT_LO sets o_error and goes to DONE. Remaining words are not transferred; the FIFO is flushed.
- DRAIN (read only): hold until the FIFO is empty, then go to DONE.
- DONE: o_done=1 for one cycle; o_busy=0 from the next cycle; return to IDLE.
- Write stream: o_wr_ready = o_busy & dir==0 & FIFO not full & (words accepted < len). Extra beats are never accepted.
- Read stream: o_rd_valid = FIFO not empty; pop on o_rd_valid & i_rd_ready.
- FIFO simultaneous push/pop: allowed in the same cycle when full or empty; occupancy unchanged.
- Exactly one SRAM transaction is outstanding at any time. No o_mem_request while i_mem_wait=1.
- Reset mid-burst: immediate return to reset values; FIFO contents lost.

Decomposition:
- Package sram_pkg:
  - state enum.
  - SRAM_ADDR_W=20, SRAM_DATA_W=16.
  - MEM_WR_READ=1'b1, MEM_WR_WRITE=1'b0.
- Sub-module sync_fifo, parameterised width and depth, exposing full/empty/count. Shared by both directions.

Test Plan:
- Read burst: base 0x00100, len 4, controller model holds wait 8 cycles and returns addr[15:0], rd_ready=1.
  -> stream 0x0100, 0x0101, 0x0102, 0x0103; 4 requests with o_mem_wr=1; one o_done; o_error=0.
- Read backpressure: len 8, FIFO_DEPTH 4, rd_ready=0 for 50 cycles.
  -> exactly 4 requests issued, then stall; the remaining 4 requests issue after ready=1; data in order.
- Write burst: base 0xFFFFE, len 3, data 0xAAAA, 0xBBBB, 0xCCCC.
  -> addresses 0xFFFFE, 0xFFFFF, 0x00000 with matching o_mem_w_value and o_mem_wr=0; o_wr_ready drops after the 3rd beat.
- Length zero: i_start with len 0.
  -> o_done the next cycle; no o_mem_request.
- Timeout: model never raises wait after the 2nd request.
  -> o_error=1 TIMEOUT cycles later, o_done pulse, FIFO empty; next i_start clears o_error.
- Reset mid-burst plus start-while-busy: i_start pulsed during a burst is ignored; i_rst low in WAIT_LO.
  -> all outputs 0 next edge; a fresh burst then runs correctly.
